alarm_monitor: RTL and testbench

//   Parametrised sequential alarm controller. N_IN sensor bits are registered and looked up in a

---
 rtl/alarm_pkg.sv | 13 +
 rtl/alarm_lut.sv | 27 ++
 rtl/alarm_monitor.sv | 112 +++++++++++
 tb/tb_alarm_monitor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state encodings for the alarm monitor slice.
package alarm_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_PENDING  = 2'd2,
      ST_ALARM    = 2'd3
   } state_t;

endpackage

// File: rtl/alarm_lut.sv
// Programmable trip table: one bit per sensor pattern, reloaded from TABLE on reset.
module alarm_lut #(
   parameter int                  N_IN  = 5,
   parameter logic [2**N_IN-1:0]  TABLE = 32'hB32D_224C
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_we,
   input  logic [N_IN-1:0] cfg_addr,
   input  logic            cfg_bit,
   input  logic [N_IN-1:0] addr,
   output logic            trip
);

   logic [2**N_IN-1:0] tbl;

   always_ff @(posedge clk) begin
      if (reset) begin
         tbl <= TABLE;
      end else if (cfg_we) begin
         tbl[cfg_addr] <= cfg_bit;
      end
   end

   assign trip = tbl[addr];

endmodule

// File: rtl/alarm_monitor.sv
// Sequential alarm controller: registered sensors, trip lookup, persistence
// qualification, latched alarm with arm/disarm/ack and a saturating event count.
module alarm_monitor
   import alarm_pkg::*;
#(
   parameter int                  N_IN    = 5,
   parameter logic [2**N_IN-1:0]  TABLE   = 32'hB32D_224C,
   parameter int                  PERSIST = 3,
   parameter int                  CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_IN-1:0]    x,
   input  logic               arm,
   input  logic               disarm,
   input  logic               ack,
   input  logic               cfg_we,
   input  logic [N_IN-1:0]    cfg_addr,
   input  logic               cfg_bit,
   output logic               trip,
   output logic               alarm,
   output logic [STATE_W-1:0] state_o,
   output logic [CNT_W-1:0]   event_cnt
);

   localparam int PCW = $clog2(PERSIST + 1);

   state_t            state;
   logic [N_IN-1:0]   x_q;
   logic [PCW-1:0]    cnt;

   alarm_lut #(
      .N_IN  (N_IN),
      .TABLE (TABLE)
   ) u_lut (
      .clk      (clk),
      .reset    (reset),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_bit  (cfg_bit),
      .addr     (x_q),
      .trip     (trip)
   );

   // Disarm outranks ack/arm, which outrank trip qualification; alarm mirrors ST_ALARM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_DISARMED;
         x_q       <= '0;
         cnt       <= '0;
         alarm     <= 1'b0;
         event_cnt <= '0;
      end else begin
         x_q <= x;
         if (disarm) begin
            state <= ST_DISARMED;
            cnt   <= '0;
            alarm <= 1'b0;
         end else begin
            case (state)
               ST_DISARMED: begin
                  if (arm) begin
                     state <= ST_ARMED;
                     cnt   <= '0;
                  end
               end
               ST_ARMED: begin
                  if (trip) begin
                     if (PERSIST == 1) begin
                        state <= ST_ALARM;
                        alarm <= 1'b1;
                        cnt   <= '0;
                        if (event_cnt != '1) event_cnt <= event_cnt + 1'b1;
                     end else begin
                        state <= ST_PENDING;
                        cnt   <= PCW'(1);
                     end
                  end
               end
               ST_PENDING: begin
                  if (!trip) begin
                     state <= ST_ARMED;
                     cnt   <= '0;
                  end else if (int'(cnt) + 1 == PERSIST) begin
                     state <= ST_ALARM;
                     alarm <= 1'b1;
                     cnt   <= '0;
                     if (event_cnt != '1) event_cnt <= event_cnt + 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_ALARM: begin
                  if (ack) begin
                     state <= ST_ARMED;
                     alarm <= 1'b0;
                     cnt   <= '0;
                  end
               end
               default: begin
                  state <= ST_DISARMED;
                  alarm <= 1'b0;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_alarm_monitor.sv
// Self-checking bench for alarm_monitor against a run-length reference model.
module tb_alarm_monitor;

   localparam int          PERSIST    = 3;
   localparam int          CNT_W      = 2;
   localparam int          EVENT_MAX  = 3;
   localparam logic [31:0] TABLE_INIT = 32'hB32D_224C;

   logic             clk;
   logic             reset;
   logic [4:0]       x;
   logic             arm, disarm, ack;
   logic             cfg_we;
   logic [4:0]       cfg_addr;
   logic             cfg_bit;
   logic             trip;
   logic             alarm;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] event_cnt;

   int compareCount  = 0;
   int mismatchCount = 0;

   bit          mArmed, mLatched;
   int          mRun, mEvents;
   logic [4:0]  mXq;
   logic [31:0] mTable;

   alarm_monitor #(
      .N_IN    (5),
      .TABLE   (TABLE_INIT),
      .PERSIST (PERSIST),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .x         (x),
      .arm       (arm),
      .disarm    (disarm),
      .ack       (ack),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_bit   (cfg_bit),
      .trip      (trip),
      .alarm     (alarm),
      .state_o   (state_o),
      .event_cnt (event_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int modelState();
      if (!mArmed)        return 0;
      else if (mLatched)  return 3;
      else if (mRun > 0)  return 2;
      else                return 1;
   endfunction

   // Reference: alarm latches once the trip run length since arming reaches PERSIST.
   task automatic modelStep();
      logic mTrip;
      mTrip = mTable[mXq];
      if (reset) begin
         mArmed = 0; mLatched = 0; mRun = 0; mEvents = 0;
         mXq = '0; mTable = TABLE_INIT;
      end else begin
         if (disarm) begin
            mArmed = 0; mLatched = 0; mRun = 0;
         end else if (!mArmed) begin
            if (arm) begin mArmed = 1; mRun = 0; end
         end else if (mLatched) begin
            if (ack) begin mLatched = 0; mRun = 0; end
         end else begin
            mRun = mTrip ? mRun + 1 : 0;
            if (mRun >= PERSIST) begin
               mLatched = 1;
               mRun = 0;
               if (mEvents < EVENT_MAX) mEvents++;
            end
         end
         mXq = x;
         if (cfg_we) mTable[cfg_addr] = cfg_bit;
      end
   endtask

   task automatic applyStimulus(input logic [4:0] xv, input logic armv, input logic disarmv,
                                input logic ackv, input logic wev, input logic [4:0] av,
                                input logic bv, input logic rstv);
      x = xv; arm = armv; disarm = disarmv; ack = ackv;
      cfg_we = wev; cfg_addr = av; cfg_bit = bv; reset = rstv;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("trip", trip, mTable[mXq]);
      checkOutput("alarm", alarm, mLatched);
      checkOutput("state", state_o, modelState());
      checkOutput("event_cnt", event_cnt, mEvents);
   endtask

   task automatic idle(input logic [4:0] xv, input int n);
      for (int i = 0; i < n; i++) applyStimulus(xv, 0, 0, 0, 0, 0, 0, 0);
   endtask

   int edges;

   initial begin
      mArmed = 0; mLatched = 0; mRun = 0; mEvents = 0; mXq = '0; mTable = TABLE_INIT;
      x = '0; arm = 0; disarm = 0; ack = 0; cfg_we = 0; cfg_addr = '0; cfg_bit = 0; reset = 1;
      #2;

      // Reset, arm, then a held trip pattern (x=3 trips in the reset table).
      applyStimulus(0, 0, 0, 0, 1, 5'd3, 0, 1);
      checkOutput("reset_state", state_o, 0);
      checkOutput("reset_trip0", trip, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      edges = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(5'd3, 0, 0, 0, 0, 0, 0, 0);
         edges++;
         if (alarm === 1'b1) break;
      end
      checkOutput("t1_latency", edges, 4);
      checkOutput("t1_events", event_cnt, 1);

      // Alarm stays latched without trip; ack returns to ARMED, then held trip re-raises.
      idle(0, 3);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("t3_ack_state", state_o, 1);
      idle(5'd3, 5);

      // Short trip run returns to ARMED.
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      idle(5'd3, 2);
      idle(0, 3);
      checkOutput("t2_no_alarm", alarm, 0);

      // Program table[0]=1 so x=0 trips; reset restores it.
      applyStimulus(0, 0, 0, 0, 1, 5'd0, 1, 0);
      idle(0, 5);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      idle(0, 2);
      checkOutput("t4_table_restored", trip, 0);

      // arm+disarm while PENDING, ack while ARMED, trip while DISARMED.
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      idle(5'd3, 2);
      applyStimulus(5'd3, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("t5_disarm_state", state_o, 0);
      idle(5'd3, 4);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("t5_ack_ignored", state_o, 1);

      // Saturate the 2-bit event counter.
      for (int k = 0; k < 5; k++) begin
         idle(5'd3, 4);
         applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
      end
      checkOutput("t6_saturated", event_cnt, 3);

      // Reset while PENDING, with a cfg write in the same cycle.
      idle(5'd3, 2);
      applyStimulus(5'd3, 0, 0, 0, 1, 5'd0, 1, 1);
      checkOutput("t6_reset_state", state_o, 0);
      checkOutput("t6_reset_events", event_cnt, 0);

      // Randomized phase; sticky x makes persistent trip runs likely.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] xv;
         xv = ($urandom_range(0, 99) < 60) ? x : 5'($urandom);
         applyStimulus(xv,
                       $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 3,
                       $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 5,
                       5'($urandom),
                       1'($urandom),
                       $urandom_range(0, 999) < 5);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
